// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared constants, state encoding and access-legality helper
//                for the lsu_md load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_RD_REQ  = ST_RD_REQ,
        S_RD_DATA = ST_RD_DATA,
        S_WR      = ST_WR,
        S_RESP    = ST_RESP
    } state_t;

    // Lane widths
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    // 1 when the request is misaligned, uses a reserved funct3, or is a
    // store with an unsigned (load-only) encoding.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic err;
        case (funct3)
            F3_B, F3_BU: err = we && funct3[2];
            F3_H, F3_HU: err = offset[0] || (we && funct3[2]);
            F3_W:        err = (offset != 2'b00);
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_md_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic: extracts and extends the addressed
//                byte/halfword of a memory word for loads, and merges store
//                data into that lane for read-modify-write stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [WIDTH-1:0]  word,
    input  logic [HALF_W-1:0] store_data,
    output logic [WIDTH-1:0]  load_data,
    output logic [WIDTH-1:0]  merged
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    // Little-endian lane select and sign/zero extension for loads
    always_comb begin
        w_byte = word[{offset, 3'b000} +: BYTE_W];
        w_half = word[{offset[1], 4'b0000} +: HALF_W];
        case (funct3)
            F3_B:    load_data = {{(WIDTH-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            F3_BU:   load_data = {{(WIDTH-BYTE_W){1'b0}}, w_byte};
            F3_H:    load_data = {{(WIDTH-HALF_W){w_half[HALF_W-1]}}, w_half};
            F3_HU:   load_data = {{(WIDTH-HALF_W){1'b0}}, w_half};
            F3_W:    load_data = word;
            default: load_data = '0;
        endcase
    end

    // Replace the addressed byte (SB) or halfword (SH) of the read word
    always_comb begin
        merged = word;
        if (funct3[1:0] == 2'b00) begin
            merged[{offset, 3'b000} +: BYTE_W] = store_data[BYTE_W-1:0];
        end else begin
            merged[{offset[1], 4'b0000} +: HALF_W] = store_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_md.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_md
//  Description : RV32I load/store unit in front of a word-wide memory with a
//                single read/write port. Sub-word stores are done as
//                read-modify-write since the memory has no byte enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_md
    import lsu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int WIDTH_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [WIDTH-1:0]      resp_rdata,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [WIDTH_BITS-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_offset;
    logic [HALF_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_err;
    logic [WIDTH-1:0]  w_load_data;
    logic [WIDTH-1:0]  w_merged;
    // Address bits above the memory size are deliberately dropped (wrap)
    logic              w_unused_addr;

    assign w_unused_addr = &{1'b0, req_addr[31:WIDTH_BITS+2]};

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign mem_ren    = (r_state == S_RD_REQ);
    assign mem_wen    = (r_state == S_WR);

    assign w_accept = req_valid && req_ready;
    assign w_err    = access_err(req_we, req_funct3, req_addr[1:0]);

    lsu_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .funct3     (r_funct3),
        .offset     (r_offset),
        .word       (mem_rdata),
        .store_data (r_wdata),
        .load_data  (w_load_data),
        .merged     (w_merged)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: errors skip memory, SW writes directly, all else reads first
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_next = S_RESP;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ:  w_next = S_RD_DATA;
            S_RD_DATA: w_next = r_we ? S_WR : S_RESP;
            S_WR:      w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Request capture and memory write-data staging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_offset  <= 2'b00;
            r_wdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_offset <= req_addr[1:0];
            r_wdata  <= req_wdata[HALF_W-1:0];
            mem_addr <= req_addr[WIDTH_BITS+1:2];
            if (req_we && (req_funct3 == F3_W)) begin
                mem_wdata <= req_wdata;
            end
        end else if ((r_state == S_RD_DATA) && r_we) begin
            mem_wdata <= w_merged;
        end
    end

    // Response registers: cleared on accept, loaded when RESP is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else if (w_accept) begin
            resp_err   <= w_err;
            resp_rdata <= '0;
        end else if ((r_state == S_RD_DATA) && !r_we) begin
            resp_rdata <= w_load_data;
        end
    end

endmodule
`default_nettype wire
